fp16_mul_arbiter: RTL
=====================

FP16_MUL_ARBITER -- requirements
Module: fp16_mul_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 1: cycles from the mul_a/mul_b update edge to mul_prod valid; legal 1..4.
REQ-002 The block SHALL have parameter DEPTH, default 4: per-requester result FIFO entries; legal DEPTH >= LAT+1.
REQ-003 The block SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESETn  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid/req1_valid  input  1  each; operand pair offered.
REQ-006 The block SHALL have ports req0_ready/req1_ready  output  1  each; grant, combinational.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  each; fp16 operands.
REQ-008 The block SHALL have ports res0_valid/res1_valid  output  1  each; FIFO head valid.
REQ-009 The block SHALL have ports res0_ready/res1_ready  input  1  each; consumer accepts head.
REQ-010 The block SHALL have ports res0_data/res1_data  output  16  each; fp16 product at FIFO head.
REQ-011 The block SHALL have ports mul_a, mul_b  output  16  each; registered operands to the shared fp16 multiplier.
REQ-012 The block SHALL have port mul_prod  input  16  product from the shared multiplier.

Function
REQ-013 Handshake on requester i SHALL occur when reqi_valid and reqi_ready are both high at a rising edge; reqi_ready SHALL NOT depend on reqi_ready of the other requester's outputs combinationally beyond arbitration.
REQ-014 Requester i SHALL be eligible when reqi_valid=1 and credit_i < DEPTH, where credit_i = FIFO occupancy + products in flight for i.
REQ-015 At most one reqi_ready SHALL be high per cycle; a single eligible requester SHALL be granted; an ineligible requester SHALL see ready=0.
REQ-016 With both eligible, the grant SHALL go to the requester not granted most recently (round-robin); the pointer SHALL update only on a handshake.
REQ-017 On handshake, mul_a/mul_b SHALL load the granted operands; with no handshake they SHALL hold their previous value.
REQ-018 A tag shift register of LAT stages (valid + requester id) SHALL track each issue; mul_prod SHALL be pushed into the tagged FIFO at edge E0+LAT+1 (E0 = handshake edge).
REQ-019 resi_valid SHALL be high from the cycle after the push; total latency from handshake edge to resi_valid = LAT+1 cycles.
REQ-020 Each FIFO SHALL be first-in first-out; pop occurs on resi_valid & resi_ready; simultaneous push and pop SHALL keep occupancy constant and both SHALL complete.
REQ-021 credit_i SHALL increment on issue and decrement on pop; simultaneous issue and pop SHALL leave it unchanged; credit ceiling guarantees a push never meets a full FIFO.
REQ-022 Back-to-back issue every cycle SHALL be sustained while credits allow; full throughput = 1 product/cycle total.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH without loss.

Reset
REQ-024 On RESETn low, asynchronously: req0_ready=req1_ready=0, res0_valid=res1_valid=0, res0_data=res1_data=16'h0000, mul_a=mul_b=16'h0000, FIFOs empty, credits 0, tags invalid, pointer set so requester 0 wins the first tie.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered products; none SHALL appear after release.
REQ-026 First handshake SHALL be possible in the first cycle after RESETn deasserts.

Configuration
REQ-027 With macro FP16_ARB_FIXED_PRIO_EN defined, ties SHALL always go to requester 0 (round-robin pointer removed); without it, REQ-016 round-robin SHALL apply.

Verification
REQ-028 LAT=1: req0 a=16'h3C00, b=16'h4000 single handshake -> res0_valid high 2 cycles later, res0_data=16'h4000; res1_valid stays 0.
REQ-029 Both valid continuously, req0 3.0*4.0 (16'h4200,16'h4400), req1 2.0*2.0 (16'h4000,16'h4000), consumers always ready -> grants alternate 0,1,0,1; res0_data=16'h4A00, res1_data=16'h4400.
REQ-030 res0_ready=0, req0 streams, DEPTH=4 -> exactly 4 handshakes then req0_ready=0; req1 still granted every cycle; raising res0_ready drains in order, no loss.
REQ-031 FIFO at DEPTH-1 with simultaneous push and pop -> occupancy unchanged, order preserved across pointer wrap.
REQ-032 RESETn pulsed low with 2 products in flight and 3 buffered -> all outputs at reset values, no resi_valid after release.
REQ-033 FP16_ARB_FIXED_PRIO_EN defined, both valid continuously -> req0 granted every cycle until its credits exhaust, then req1 granted.

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// Two-requester arbiter in front of one shared fp16 multiplier, with credit-limited per-requester result FIFOs.
// Define FP16_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module fp16_mul_arbiter #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        res0_valid,
  output logic        res1_valid,
  input  logic        res0_ready,
  input  logic        res1_ready,
  output logic [15:0] res0_data,
  output logic [15:0] res1_data,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_prod
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    w_elig;
  logic [1:0]    w_gnt;
  logic [1:0]    w_hs;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_resReady;
  logic [CW-1:0] r_credit [2];
  logic [CW-1:0] r_cnt [2];
  logic [AW-1:0] r_wr [2];
  logic [AW-1:0] r_rd [2];
  logic [15:0]   r_mem [2][DEPTH];
  logic [LAT:0]  r_tagV;
  logic [LAT:0]  r_tagId;
  logic [15:0]   r_mulA;
  logic [15:0]   r_mulB;

  // Credits count buffered plus in-flight products, so a push can never find its FIFO full.
  assign w_elig[0] = req0_valid & (r_credit[0] < CW'(DEPTH));
  assign w_elig[1] = req1_valid & (r_credit[1] < CW'(DEPTH));

`ifdef FP16_ARB_FIXED_PRIO_EN
  assign w_gnt[0] = w_elig[0];
  assign w_gnt[1] = w_elig[1] & ~w_elig[0];
`else
  logic r_last;

  assign w_gnt[0] = w_elig[0] & (~w_elig[1] | r_last);
  assign w_gnt[1] = w_elig[1] & (~w_elig[0] | ~r_last);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_last <= 1'b1;
    end else if (|w_hs) begin
      r_last <= w_hs[1];
    end
  end
`endif

  assign req0_ready = RESETn & w_gnt[0];
  assign req1_ready = RESETn & w_gnt[1];
  assign w_hs       = {req1_ready, req0_ready};
  assign w_resReady = {res1_ready, res0_ready};

  // Tag stage 0 sits beside the operand registers; stage LAT lines up with a valid mul_prod.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_tagV  <= '0;
      r_tagId <= '0;
      r_mulA  <= 16'h0000;
      r_mulB  <= 16'h0000;
    end else begin
      r_tagV  <= {r_tagV[LAT-1:0], |w_hs};
      r_tagId <= {r_tagId[LAT-1:0], w_hs[1]};
      if (w_hs[0]) begin
        r_mulA <= req0_a;
        r_mulB <= req0_b;
      end else if (w_hs[1]) begin
        r_mulA <= req1_a;
        r_mulB <= req1_b;
      end
    end
  end

  assign mul_a     = r_mulA;
  assign mul_b     = r_mulB;
  assign w_push[0] = r_tagV[LAT] & ~r_tagId[LAT];
  assign w_push[1] = r_tagV[LAT] & r_tagId[LAT];
  assign w_pop[0]  = (r_cnt[0] != '0) & w_resReady[0];
  assign w_pop[1]  = (r_cnt[1] != '0) & w_resReady[1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < 2; i++) begin
        r_credit[i] <= '0;
        r_cnt[i]    <= '0;
        r_wr[i]     <= '0;
        r_rd[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_hs[i] && !w_pop[i]) begin
          r_credit[i] <= r_credit[i] + CW'(1);
        end else if (!w_hs[i] && w_pop[i]) begin
          r_credit[i] <= r_credit[i] - CW'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_push[i] && w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
        if (w_push[i]) begin
          r_wr[i] <= (r_wr[i] == AW'(DEPTH - 1)) ? '0 : r_wr[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rd[i] <= (r_rd[i] == AW'(DEPTH - 1)) ? '0 : r_rd[i] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr[i]] <= mul_prod;
      end
    end
  end

  // Data is forced to zero whenever the head is empty so reset and idle outputs are deterministic.
  assign res0_valid = (r_cnt[0] != '0);
  assign res1_valid = (r_cnt[1] != '0);
  assign res0_data  = res0_valid ? r_mem[0][r_rd[0]] : 16'h0000;
  assign res1_data  = res1_valid ? r_mem[1][r_rd[1]] : 16'h0000;

endmodule
